// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings and frame constants
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Start-bit confirmation point, also the offset that centres data sampling.
  function automatic int half_bit(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a single asynchronous input
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic nRst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with glitch rejection and break handling
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1042
) (
  input  logic                 clk,
  input  logic                 nRst,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_ready,
  output logic                 framing_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF     = CW'(half_bit(CLKS_PER_BIT));
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_t            state;
  logic                 rx_sync;
  logic [CW-1:0]        clk_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_reg;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk  (clk),
    .nRst (nRst),
    .d    (rx_serial),
    .q    (rx_sync)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      rx_byte     <= '0;
      rx_ready    <= 1'b0;
      framing_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rx_ready    <= 1'b0;
      framing_err <= 1'b0;
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (!rx_sync) begin
            state <= START;
            busy  <= 1'b1;
          end
        end

        // A start bit still low at its midpoint is real; anything shorter is noise.
        START: begin
          if (clk_cnt == HALF) begin
            clk_cnt <= '0;
            if (!rx_sync) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        DATA: begin
          if (clk_cnt == LAST) begin
            clk_cnt            <= '0;
            shift_reg[bit_idx] <= rx_sync;
            bit_idx            <= bit_idx + 1'b1;
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        STOP: begin
          if (clk_cnt == LAST) begin
            clk_cnt <= '0;
            if (rx_sync) begin
              rx_byte  <= shift_reg;
              rx_ready <= 1'b1;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              framing_err <= 1'b1;
              state       <= BREAK;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        // Hold here so a line stuck low reports one error, not one per frame time.
        BREAK: begin
          clk_cnt <= '0;
          if (rx_sync) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
